// File: rtl/sar_pkg.sv
// Shared types and limits for the SAR ADC controller.
// Holds the FSM state encoding, parameter limits and a counter width helper.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        DONE
    } sar_state_t;

    localparam int N_BITS_MIN     = 2;
    localparam int N_BITS_MAX     = 12;
    localparam int SAMPLE_CYC_MIN = 1;
    localparam int SAMPLE_CYC_MAX = 15;

    // Wide enough for SAMPLE_CYC_MAX - 1
    localparam int SAMPLE_CNT_W = 4;

    // Width of a bit-index counter covering 0..n-1
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_ctrl.sv
// Successive-approximation controller: sample, binary search, publish code.
// Ports: clk, rst_n (async low), en_i, cmp_i in; sample_o, dac_o,
//        busy_o, data_o, valid_o out (all registered).
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int N_BITS     = 8,
    parameter int SAMPLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              cmp_i,
    output logic              sample_o,
    output logic [N_BITS-1:0] dac_o,
    output logic              busy_o,
    output logic [N_BITS-1:0] data_o,
    output logic              valid_o
);

    localparam int IW = idx_width(N_BITS);
    localparam int CW = SAMPLE_CNT_W;

    localparam logic [IW-1:0]     IDX_MSB  = IW'(N_BITS - 1);
    localparam logic [CW-1:0]     CNT_LOAD = CW'(SAMPLE_CYC - 1);
    localparam logic [N_BITS-1:0] ONE      = N_BITS'(1);
    localparam logic [N_BITS-1:0] MSB_MASK = ONE << (N_BITS - 1);

    if (N_BITS < N_BITS_MIN || N_BITS > N_BITS_MAX ||
        SAMPLE_CYC < SAMPLE_CYC_MIN ||
        SAMPLE_CYC > SAMPLE_CYC_MAX) begin : g_param_check
        $error("sar_ctrl: N_BITS or SAMPLE_CYC out of range");
    end

    sar_state_t        state;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [N_BITS-1:0] code;

    logic              start;
    logic [IW-1:0]     idx_dn;
    logic [N_BITS-1:0] code_res;
    logic [N_BITS-1:0] dac_next;

    // A new conversion may only begin from IDLE or straight out of DONE.
    // Bits at and below idx are still 0, so OR-ing in the decision is exact.
    always_comb begin
        start    = en_i && (state == IDLE || state == DONE);
        idx_dn   = idx - 1'b1;
        code_res = code | (cmp_i ? (ONE << idx) : '0);
        dac_next = code_res | (ONE << idx_dn);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            code     <= '0;
            sample_o <= 1'b0;
            dac_o    <= '0;
            busy_o   <= 1'b0;
            data_o   <= '0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (start) begin
                // First trial code is presented already while sampling
                state    <= SAMPLE;
                cnt      <= CNT_LOAD;
                idx      <= IDX_MSB;
                code     <= '0;
                sample_o <= 1'b1;
                dac_o    <= MSB_MASK;
                busy_o   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        sample_o <= 1'b0;
                        dac_o    <= '0;
                        busy_o   <= 1'b0;
                    end
                    SAMPLE: begin
                        if (cnt == '0) begin
                            state    <= CONVERT;
                            sample_o <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    CONVERT: begin
                        code <= code_res;
                        if (idx == '0) begin
                            state   <= DONE;
                            data_o  <= code_res;
                            valid_o <= 1'b1;
                            dac_o   <= code_res;
                        end else begin
                            idx   <= idx_dn;
                            dac_o <= dac_next;
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        dac_o  <= '0;
                        busy_o <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sar_ctrl.sv
// Scoreboard bench for sar_ctrl with an ideal comparator driven by a target.
// Covers reset, single/continuous conversions, enable drop and a 12-bit build.
module tb_sar_ctrl;

    localparam int N   = 8;
    localparam int SC  = 2;
    localparam int P   = SC + N + 1;
    localparam int N2  = 12;
    localparam int SC2 = 1;

    typedef struct {
        int code;
        int at;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic cmp;
    logic sample;
    logic busy;
    logic valid;
    logic [N-1:0] dac;
    logic [N-1:0] data;

    logic en2 = 1'b0;
    logic cmp2;
    logic sample2;
    logic busy2;
    logic valid2;
    logic [N2-1:0] dac2;
    logic [N2-1:0] data2;

    int mode   = 0;
    int target = 0;
    int t2     = 0;
    int cyc    = 0;

    int vectors     = 0;
    int miscompares = 0;

    exp_t sb[$];
    int   dq[$];
    int   bm[8];
    int   bt[8];

    // mode 0: ideal comparator, 1: stuck high, 2: stuck low
    assign cmp  = (mode == 1) ? 1'b1 :
                  (mode == 2) ? 1'b0 : (target >= int'(dac));
    assign cmp2 = (t2 >= int'(dac2));

    sar_ctrl #(.N_BITS(N), .SAMPLE_CYC(SC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en),
        .cmp_i   (cmp),
        .sample_o(sample),
        .dac_o   (dac),
        .busy_o  (busy),
        .data_o  (data),
        .valid_o (valid)
    );

    sar_ctrl #(.N_BITS(N2), .SAMPLE_CYC(SC2)) dut12 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (en2),
        .cmp_i   (cmp2),
        .sample_o(sample2),
        .dac_o   (dac2),
        .busy_o  (busy2),
        .data_o  (data2),
        .valid_o (valid2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
    endtask

    // Result a binary search converges to for a given comparator behaviour
    function automatic int eff(input int m, input int t);
        if (m == 1) return (1 << N) - 1;
        if (m == 2) return 0;
        return t;
    endfunction

    // Conversion started at edge k: code appears k+SC+N edges later, and
    // each trial is the already-resolved upper bits plus the bit under test.
    task automatic push_conv(input int k, input int e);
        sb.push_back('{code: e, at: k + SC + N});
        for (int i = N - 1; i >= 0; i--)
            dq.push_back(((e >> (i + 1)) << (i + 1)) | (1 << i));
    endtask

    int   conv_left = 0;
    logic prev_s    = 1'b0;
    logic prev_v    = 1'b0;
    logic [N-1:0] prev_d = '0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            conv_left = 0;
            prev_s    = 1'b0;
            prev_v    = 1'b0;
            prev_d    = data;
        end else begin
            if (prev_s && !sample) conv_left = N;
            if (conv_left > 0) begin
                if (dq.size() == 0) flag("dac_unexpected");
                else check("dac_trial", dac, dq.pop_front());
                conv_left--;
            end
            if (valid) begin
                check("valid_gap", prev_v, 0);
                if (sb.size() == 0) begin
                    flag("valid_unexpected");
                end else begin
                    mon_e = sb.pop_front();
                    check("data", data, mon_e.code);
                    check("valid_cycle", cyc, mon_e.at);
                end
            end else begin
                check("data_hold", data, prev_d);
            end
            prev_s = sample;
            prev_v = valid;
            prev_d = data;
        end
    end

    task automatic single(input int m, input int t);
        int k;
        mode   = m;
        target = t;
        en     = 1'b1;
        k      = cyc + 1;
        push_conv(k, eff(m, t));
        @(negedge clk);
        en = 1'b0;
        repeat (SC + N + 1) @(negedge clk);
        check("idle_after", busy, 0);
    endtask

    task automatic burst(input int n);
        int k;
        mode   = bm[0];
        target = bt[0];
        en     = 1'b1;
        k      = cyc + 1;
        for (int j = 0; j < n; j++)
            push_conv(k + j * P, eff(bm[j], bt[j]));
        for (int j = 0; j < n; j++) begin
            while (cyc < k + j * P + SC + N) @(negedge clk);
            if (j == n - 1) begin
                en = 1'b0;
            end else begin
                mode   = bm[j + 1];
                target = bt[j + 1];
                @(negedge clk);
                check("resample", sample, 1);
            end
        end
        repeat (2) @(negedge clk);
        check("burst_idle", busy, 0);
    endtask

    task automatic conv12(input int t);
        int k;
        int n;
        t2  = t;
        en2 = 1'b1;
        k   = cyc + 1;
        @(negedge clk);
        en2 = 1'b0;
        n   = 0;
        while (!valid2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!valid2) begin
            vectors++;
            miscompares++;
            $display("FAIL conv12_timeout: got no valid, expected one");
        end else begin
            check("conv12_data", data2, t);
            check("conv12_latency", cyc - k, SC2 + N2);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k;
        int n;
        repeat (3) @(negedge clk);
        check("rst_sample", sample, 0);
        check("rst_dac", dac, 0);
        check("rst_busy", busy, 0);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        single(0, 'hA5);
        single(1, 0);
        single(2, 0);

        bm[0] = 0; bt[0] = 'h3C;
        bm[1] = 0; bt[1] = 'hC3;
        burst(2);

        // Enable dropped while bit 5 is under test
        mode   = 0;
        target = $urandom_range(0, 255);
        en     = 1'b1;
        k      = cyc + 1;
        push_conv(k, target);
        while (cyc < k + SC + 2) @(negedge clk);
        en = 1'b0;
        while (cyc < k + SC + N + 1) @(negedge clk);
        check("drop_idle", busy, 0);
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            check("drop_no_sample", sample, 0);
        end

        // Reset in the middle of a conversion
        mode   = 0;
        target = $urandom_range(0, 255);
        en     = 1'b1;
        k      = cyc + 1;
        push_conv(k, target);
        @(negedge clk);
        en = 1'b0;
        while (cyc < k + SC + 4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sample", sample, 0);
        check("mid_rst_dac", dac, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_valid", valid, 0);
        sb.delete();
        dq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (P + 3) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_sample", sample, 0);

        for (int r = 0; r < 12; r++) begin
            int m;
            m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            single(m, $urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(2, 4);
            for (int j = 0; j < n; j++) begin
                bm[j] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
                bt[j] = $urandom_range(0, 255);
            end
            burst(n);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        conv12('h800);
        conv12('h7FF);
        conv12('hFFF);
        conv12(0);
        for (int r = 0; r < 4; r++) conv12($urandom_range(0, 4095));

        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending results, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
